// File: rtl/lane_arb_pkg.sv
// Shared definitions for the lane round-robin arbiter.
//
// Contents:
//   DEF_NUM_LANES : default number of lane FIFOs served
//   DEF_DATA_W    : default FIFO word width
//   CNT_W         : width of each per-lane accepted-word counter
//   arb_state_t   : arbiter FSM state encoding
package lane_arb_pkg;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,  // waiting for an active link and a non-empty lane
        ARB_POP  = 2'd1,  // lane chosen, confirm it is still non-empty
        ARB_WAIT = 2'd2,  // pop strobe out, capture the word being read
        ARB_HOLD = 2'd3   // word presented, waiting for the downstream handshake
    } arb_state_t;

endpackage

// File: rtl/lane_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//
// Chooses, among the requesting lanes, the one that comes first when
// counting upward from last+1 with wrap-around; the lane equal to last has
// the lowest priority.
//
// Ports:
//   req     in   NUM_LANES  request vector (1 = lane has data)
//   last    in   LANE_W     most recently served lane
//   grant   out  LANE_W     chosen lane (0 when nothing requests)
//   any_req out  1          at least one lane requests
module rr_pick #(
    parameter  int NUM_LANES = 4,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    last,
    output logic [LANE_W-1:0]    grant,
    output logic                 any_req
);

    logic              found;
    logic [LANE_W-1:0] idx;

    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // NUM_LANES is a power of two, so the LANE_W-bit add wraps for free;
        // the final iteration (k == NUM_LANES) lands back on last itself.
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = last + LANE_W'(k);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/lane_rr_arbiter.sv
// Round-robin arbiter draining the per-lane receive byte FIFOs into a single
// byte stream. One word is in flight at a time; a lane is re-checked for
// data right before its pop so a FIFO is never underflowed.
//
// Optional feature macro: LANE_ARB_STATS_EN adds the grant_cnt port with
// saturating per-lane accepted-word counters.
//
// Ports:
//   clk          in   1                  clock, rising edge
//   reset        in   1                  asynchronous, active-high reset
//   active       in   1                  link active; 0 blocks new grants
//   fifo_empty   in   NUM_LANES          per-lane empty flags
//   fifo_rd_data in   NUM_LANES*DATA_W   per-lane read data, lane i at [i*DATA_W +: DATA_W]
//   fifo_pop     out  NUM_LANES          one-hot registered read strobe
//   out_data     out  DATA_W             granted word
//   out_lane     out  LANE_W             lane the word came from
//   out_valid    out  1                  out_data/out_lane valid
//   out_ready    in   1                  downstream accepts when out_valid & out_ready
//   grant_cnt    out  NUM_LANES*CNT_W    per-lane accepted-word counters (LANE_ARB_STATS_EN only)
module lane_rr_arbiter
    import lane_arb_pkg::*;
#(
    parameter  int NUM_LANES = DEF_NUM_LANES,
    parameter  int DATA_W    = DEF_DATA_W,
    localparam int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        active,
    input  logic [NUM_LANES-1:0]        fifo_empty,
    input  logic [NUM_LANES*DATA_W-1:0] fifo_rd_data,
    output logic [NUM_LANES-1:0]        fifo_pop,
    output logic [DATA_W-1:0]           out_data,
    output logic [LANE_W-1:0]           out_lane,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef LANE_ARB_STATS_EN
    ,
    output logic [NUM_LANES*CNT_W-1:0]  grant_cnt
`endif
);

    arb_state_t            state, state_d;
    logic [LANE_W-1:0]     sel, sel_d;
    logic [LANE_W-1:0]     last, last_d;
    logic [NUM_LANES-1:0]  pop_d;
    logic [DATA_W-1:0]     data_d;
    logic [LANE_W-1:0]     lane_d;
    logic                  valid_d;

    logic [LANE_W-1:0]     pick_base;
    logic [LANE_W-1:0]     pick_lane;
    logic                  pick_any;

    // One picker serves both decision points: from IDLE the rotation starts
    // after the last served lane, from HOLD it starts after the lane being
    // retired (which becomes last on that same edge).
    assign pick_base = (state == ARB_HOLD) ? sel : last;

    rr_pick #(
        .NUM_LANES (NUM_LANES)
    ) u_pick (
        .req     (~fifo_empty),
        .last    (pick_base),
        .grant   (pick_lane),
        .any_req (pick_any)
    );

    always_comb begin
        state_d = state;
        sel_d   = sel;
        last_d  = last;
        pop_d   = '0;
        data_d  = out_data;
        lane_d  = out_lane;
        valid_d = out_valid;

        unique case (state)
            ARB_IDLE: begin
                if (active && pick_any) begin
                    sel_d   = pick_lane;
                    state_d = ARB_POP;
                end
            end

            ARB_POP: begin
                // The lane may have drained since it was chosen; back off
                // rather than pop an empty FIFO.
                if (!fifo_empty[sel]) begin
                    pop_d[sel] = 1'b1;
                    state_d    = ARB_WAIT;
                end else begin
                    state_d = ARB_IDLE;
                end
            end

            ARB_WAIT: begin
                data_d  = fifo_rd_data[sel*DATA_W +: DATA_W];
                lane_d  = sel;
                valid_d = 1'b1;
                state_d = ARB_HOLD;
            end

            ARB_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = sel;
                    if (active && pick_any) begin
                        sel_d   = pick_lane;
                        state_d = ARB_POP;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            sel       <= '0;
            last      <= LANE_W'(NUM_LANES - 1);
            fifo_pop  <= '0;
            out_data  <= '0;
            out_lane  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            last      <= last_d;
            fifo_pop  <= pop_d;
            out_data  <= data_d;
            out_lane  <= lane_d;
            out_valid <= valid_d;
        end
    end

`ifdef LANE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_LANES];

    // NOTE: this small array is built from flops, not a RAM macro, so it is
    // cleared by reset like any other state; RAM-backed storage would not be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (out_valid && out_ready && (cnt_q[out_lane] != '1)) begin
            cnt_q[out_lane] <= cnt_q[out_lane] + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_cnt
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Self-checking bench for lane_rr_arbiter: a per-cycle vector table, hand
// sequences for the multi-cycle corner cases, and randomized runs compared
// against a transaction-level round-robin model over per-lane queues.
module tb_lane_rr_arbiter;
    import lane_arb_pkg::*;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int LW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              active;
    logic [NL-1:0]     fifo_empty;
    logic [NL*DW-1:0]  fifo_rd_data;
    logic [NL-1:0]     fifo_pop;
    logic [DW-1:0]     out_data;
    logic [LW-1:0]     out_lane;
    logic              out_valid;
    logic              out_ready;
`ifdef LANE_ARB_STATS_EN
    logic [NL*CNT_W-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    lane_rr_arbiter #(.NUM_LANES(NL), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .active       (active),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_pop     (fifo_pop),
        .out_data     (out_data),
        .out_lane     (out_lane),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef LANE_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt)
`endif
    );

    typedef logic [7:0] byte_q_t[$];
    typedef struct { int lane; int data; int cyc; } hs_t;
    typedef struct {
        bit         rst;
        bit         act;
        logic [3:0] emp;
        logic [31:0] rd;
        bit         rdy;
        logic [3:0] pop;
        bit         v;
        logic [7:0] d;
        logic [1:0] l;
    } vec_t;

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;
    bit      model_en = 1'b0;
    byte_q_t q [NL];
    hs_t     got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present the queue heads as show-ahead FIFO outputs.
    task automatic refresh();
        for (int i = 0; i < NL; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_rd_data[i*DW +: DW] = (q[i].size() != 0) ? q[i][0] : 8'h00;
        end
    endtask

    // Entered and left at a falling edge; logs handshakes and applies pops.
    task automatic step();
        logic [NL-1:0] pop_seen;
        pop_seen = fifo_pop;
        if (out_valid && out_ready)
            got.push_back('{int'(out_lane), int'(out_data), cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (model_en) begin
            for (int i = 0; i < NL; i++)
                if (pop_seen[i] && q[i].size() != 0) void'(q[i].pop_front());
            refresh();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        active = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NL; i++) q[i].delete();
        got.delete();
        refresh();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_hs(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        check({name, ".count"}, got.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[$];
        byte_q_t m [NL];
        int      exp_lane[$];
        int      exp_data[$];
        int      k, bad, last_m, remaining;
        bit      prev_stall;
        logic [7:0] prev_d;
        logic [1:0] prev_l;
        int      exp_l[5];
        int      exp_d[5];

        reset = 1'b1;
        active = 1'b0;
        out_ready = 1'b0;
        fifo_empty = '1;
        fifo_rd_data = '0;
        @(negedge clk);
        check("rst.pop",   fifo_pop,  4'b0000);
        check("rst.valid", out_valid, 1'b0);
        check("rst.data",  out_data,  8'h00);
        check("rst.lane",  out_lane,  2'd0);
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        // Each row: inputs held through one rising edge, outputs expected after it.
        // Single word from lane 0.
        tbl.push_back('{1'b1, 1'b1, 4'b1110, 32'h0000_00A5, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1110, 32'h0000_00A5, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1110, 32'h0000_00A5, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        // Lane 2 chosen, then drains before the pop: no pop, no word.
        tbl.push_back('{1'b1, 1'b1, 4'b1011, 32'h003C_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        // Lanes 1 and 2 ready, last still 3: lane 1 goes first.
        tbl.push_back('{1'b0, 1'b1, 4'b1001, 32'h003C_5A00, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1001, 32'h003C_5A00, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 4'b1001, 32'h003C_5A00, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd1});
        // Link inactive: nothing granted even with data everywhere.
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 32'h1234_5678, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 32'h1234_5678, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 32'h1234_5678, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0});

        model_en = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            active       = tbl[i].act;
            fifo_empty   = tbl[i].emp;
            fifo_rd_data = tbl[i].rd;
            out_ready    = tbl[i].rdy;
            step();
            check($sformatf("tbl%0d.pop", i),   fifo_pop,  tbl[i].pop);
            check($sformatf("tbl%0d.valid", i), out_valid, tbl[i].v);
            if (tbl[i].v) begin
                check($sformatf("tbl%0d.data", i), out_data, tbl[i].d);
                check($sformatf("tbl%0d.lane", i), out_lane, tbl[i].l);
            end
        end

        // ---------------- all lanes busy: order and throughput ----------------
        model_en = 1'b1;
        do_reset();
        q[0].push_back(8'h10); q[0].push_back(8'h20);
        q[1].push_back(8'h11);
        q[2].push_back(8'h12);
        q[3].push_back(8'h13);
        refresh();
        active = 1'b1;
        out_ready = 1'b1;
        run_until_hs(5, 40, "rr4");
        exp_l = '{0, 1, 2, 3, 0};
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            check($sformatf("rr4.lane%0d", i), got[i].lane, exp_l[i]);
            check($sformatf("rr4.data%0d", i), got[i].data, exp_d[i]);
            if (i > 0) check($sformatf("rr4.gap%0d", i), got[i].cyc - got[i-1].cyc, 3);
        end

        // ---------------- back-pressure in HOLD ----------------
        do_reset();
        q[0].push_back(8'h31);
        q[1].push_back(8'h42);
        refresh();
        active = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin step(); k++; end
        check("stall.latency", k, 3);
        check("stall.data", out_data, 8'h31);
        check("stall.lane", out_lane, 2'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!(out_valid && out_data == 8'h31 && out_lane == 2'd0 && fifo_pop == '0)) bad++;
        end
        check("stall.stable", bad, 0);
        out_ready = 1'b1;
        step();
        step();
        check("stall.next_pop", fifo_pop, 4'b0010);
        run_until_hs(2, 10, "stall.second");
        if (got.size() == 2) begin
            check("stall.w0", got[0].data, 8'h31);
            check("stall.w1", got[1].data, 8'h42);
            check("stall.l1", got[1].lane, 1);
        end

        // ---------------- active drops during WAIT ----------------
        do_reset();
        for (int i = 0; i < NL; i++) begin
            q[i].push_back(8'h50 + 8'(i));
            q[i].push_back(8'h60 + 8'(i));
        end
        refresh();
        active = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (fifo_pop == '0 && k < 10) begin step(); k++; end
        check("actfall.pop", fifo_pop, 4'b0001);
        active = 1'b0;
        step();
        check("actfall.valid", out_valid, 1'b1);
        check("actfall.data", out_data, 8'h50);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fifo_pop != '0 || out_valid) bad++;
        end
        check("actfall.quiet", bad, 0);
        active = 1'b1;
        run_until_hs(2, 12, "actfall.resume");
        if (got.size() == 2) check("actfall.next_lane", got[1].lane, 1);

        // ---------------- asynchronous reset while holding a word ----------------
        do_reset();
        q[3].push_back(8'h77);
        refresh();
        active = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin step(); k++; end
        check("rsthold.data", out_data, 8'h77);
        check("rsthold.lane", out_lane, 2'd3);
        #2;
        reset = 1'b1;
        #1;
        check("rsthold.valid0", out_valid, 1'b0);
        check("rsthold.data0",  out_data,  8'h00);
        check("rsthold.lane0",  out_lane,  2'd0);
        check("rsthold.pop0",   fifo_pop,  4'b0000);
        do_reset();
        q[0].push_back(8'h01);
        q[3].push_back(8'h02);
        refresh();
        active = 1'b1;
        out_ready = 1'b1;
        run_until_hs(2, 20, "rsthold.after");
        if (got.size() == 2) begin
            check("rsthold.first_lane", got[0].lane, 0);
            check("rsthold.second_lane", got[1].lane, 3);
        end

        // ---------------- randomized runs against a round-robin model ----------------
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int i = 0; i < NL; i++) begin
                int n;
                n = $urandom_range(0, 6);
                for (int j = 0; j < n; j++) q[i].push_back(8'($urandom));
            end
            // Expected delivery order: repeatedly take the first non-empty
            // lane after the previously served one, starting after lane NL-1.
            exp_lane.delete();
            exp_data.delete();
            remaining = 0;
            for (int i = 0; i < NL; i++) begin
                m[i] = q[i];
                remaining += m[i].size();
            end
            last_m = NL - 1;
            while (remaining > 0) begin
                for (int s = 1; s <= NL; s++) begin
                    int l;
                    l = (last_m + s) % NL;
                    if (m[l].size() != 0) begin
                        exp_lane.push_back(l);
                        exp_data.push_back(int'(m[l].pop_front()));
                        last_m = l;
                        remaining--;
                        break;
                    end
                end
            end
            refresh();
            bad = 0;
            prev_stall = 1'b0;
            prev_d = '0;
            prev_l = '0;
            k = 0;
            while (got.size() < exp_lane.size() && k < 2000) begin
                if (fifo_pop != '0) begin
                    if (!$onehot(fifo_pop) || out_valid || ((fifo_pop & fifo_empty) != '0)) bad++;
                end
                if (prev_stall && !(out_valid && out_data == prev_d && out_lane == prev_l)) bad++;
                active    = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                prev_stall = out_valid && !out_ready;
                prev_d = out_data;
                prev_l = out_lane;
                step();
                k++;
            end
            active = 1'b1;
            out_ready = 1'b1;
            for (int i = 0; i < 6; i++) step();
            check($sformatf("rand%0d.count", round), got.size(), exp_lane.size());
            check($sformatf("rand%0d.invariants", round), bad, 0);
            for (int i = 0; i < exp_lane.size() && i < got.size(); i++) begin
                check($sformatf("rand%0d.lane%0d", round, i), got[i].lane, exp_lane[i]);
                check($sformatf("rand%0d.data%0d", round, i), got[i].data, exp_data[i]);
            end
        end

`ifdef LANE_ARB_STATS_EN
        // ---------------- statistics counters ----------------
        do_reset();
        for (int j = 0; j < 5; j++) q[2].push_back(8'(j));
        refresh();
        active = 1'b1;
        out_ready = 1'b1;
        run_until_hs(5, 60, "stats.run");
        step();
        check("stats.lane0", grant_cnt[0*CNT_W +: CNT_W], 16'd0);
        check("stats.lane1", grant_cnt[1*CNT_W +: CNT_W], 16'd0);
        check("stats.lane2", grant_cnt[2*CNT_W +: CNT_W], 16'd5);
        check("stats.lane3", grant_cnt[3*CNT_W +: CNT_W], 16'd0);
        dut.cnt_q[1] = 16'hFFFE;
        got.delete();
        q[1].push_back(8'hAA);
        q[1].push_back(8'hBB);
        refresh();
        run_until_hs(2, 20, "stats.sat");
        step();
        check("stats.saturate", grant_cnt[1*CNT_W +: CNT_W], 16'hFFFF);
        check("stats.lane2_kept", grant_cnt[2*CNT_W +: CNT_W], 16'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lane_rr_arbiter.md
# lane_rr_arbiter

Round-robin arbiter that drains the four per-lane byte FIFOs of the physical-layer receive path into a single byte stream toward the upper layer. It sits downstream of the idle-recirculation block and only schedules reads while the link is active. It guarantees fair, one-word-at-a-time service per lane and never underflows a FIFO.

## Interface
- NUM_LANES, 4, number of lane FIFOs served (power of two, ≥2)
- DATA_W, 8, FIFO word width
- LANE_W, $clog2(NUM_LANES), lane index width (derived, not overridden)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- active  in  1  link active (not IDLE); 0 blocks new grants
- fifo_empty  in  NUM_LANES  per-lane empty flag
- fifo_rd_data  in  NUM_LANES*DATA_W  per-lane read data, lane i at [i*DATA_W +: DATA_W], valid one cycle after pop
- fifo_pop  out  NUM_LANES  one-hot read strobe, registered
- out_data  out  DATA_W  granted word
- out_lane  out  LANE_W  lane the word came from
- out_valid  out  1  out_data/out_lane valid
- out_ready  in  1  downstream accepts word when out_valid & out_ready
- grant_cnt  out  NUM_LANES*16  per-lane accepted-word counters (only with LANE_ARB_STATS_EN)

## Operation
- FSM states: IDLE, POP, WAIT, HOLD.
- IDLE: if active and any fifo_empty bit is 0, pick lane by round-robin starting at last+1 (mod NUM_LANES), latch into sel, go to POP; else stay.
- POP: fifo_pop = onehot(sel) if fifo_empty[sel]==0, else fifo_pop = 0 and return to IDLE (no underflow). Go to WAIT after a pop.
- WAIT: capture fifo_rd_data[sel] into out_data, sel into out_lane, set out_valid; go to HOLD.
- HOLD: hold out_valid, out_data, out_lane stable until out_ready. On handshake: clear out_valid, last <= sel; if active and any lane non-empty, pick next lane (RR from sel+1), go to POP; else go to IDLE.
- Round-robin: lane with lowest (i - last - 1) mod NUM_LANES among non-empty lanes; last resets to NUM_LANES-1 so lane 0 is served first.
- active deasserted mid-transfer: in-flight word completes normally (POP/WAIT/HOLD run to handshake), then IDLE; no new pop issued.
- Reset mid-operation: state, outputs and counters clear immediately; captured word is discarded.
- Reset values: fifo_pop 0, out_valid 0, out_data 0, out_lane 0, grant_cnt 0, state IDLE, last NUM_LANES-1.

## Timing
- fifo_pop asserts for exactly one cycle per granted word, the cycle after the grant decision.
- FIFO read latency 1: out_valid rises 2 cycles after fifo_pop's decision cycle (POP→WAIT→HOLD).
- Best-case throughput one word per 3 cycles (HOLD with out_ready=1 → POP → WAIT).
- At most one word in flight; fifo_pop never asserts while out_valid=1 and out_ready=0.
- Combinational paths: none from out_ready or fifo_empty to any output.

## Configuration
- LANE_ARB_STATS_EN defined: grant_cnt port present; counter[out_lane] increments by 1 on every handshake, saturates at 16'hFFFF, cleared only by reset.
- Not defined: grant_cnt port and counters absent; arbitration behaviour identical.

## Structure
- Package lane_arb_pkg: FSM state typedef and encodings (ARB_IDLE, ARB_POP, ARB_WAIT, ARB_HOLD), default NUM_LANES/DATA_W constants, counter width constant (16).
- Sub-module rr_pick: combinational round-robin picker (req vector, last index → grant index, any_req); instanced twice or shared between IDLE and HOLD decisions.

## Test plan
- Reset, active=1, fifo_empty=4'b1110, lane0 data 8'hA5, out_ready=1 → fifo_pop=4'b0001 once, out_data=8'hA5, out_lane=0, out_valid one cycle.
- All lanes non-empty holding 8'h10/11/12/13, out_ready=1 → served order 0,1,2,3,0, one word per 3 cycles.
- out_ready=0 for 10 cycles during HOLD → out_valid, out_data stable, no fifo_pop; release → handshake, next lane popped.
- active falls during WAIT → current word delivered, then IDLE with no pop while fifo_empty=4'b0000.
- Lane empties between grant and POP (fifo_empty[sel] rises) → no pop, return to IDLE, no out_valid; reset asserted in HOLD → all outputs 0 asynchronously.
- With LANE_ARB_STATS_EN: 5 words from lane 2 → grant_cnt lane 2 = 5, others 0; forced counter 16'hFFFF stays at 16'hFFFF after further grants.
